vga_sync_generator: RTL
=======================

VGA_SYNC_GENERATOR -- requirements
Module: vga_sync_generator

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, meaning horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, meaning hsync pulse width in pixels.
REQ-004 The block SHALL have parameter H_BACK, default 48, meaning horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_VISIBLE, default 480, meaning active lines per frame.
REQ-006 The block SHALL have parameter V_FRONT, default 10, meaning vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, meaning vsync pulse width in lines.
REQ-008 The block SHALL have parameter V_BACK, default 33, meaning vertical back porch in lines.
REQ-009 The block SHALL have port vga_clock, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-010 The block SHALL have port reset, input, 1, meaning reset; it is synchronous and active-high.
REQ-011 The block SHALL have port pixel_enable, input, 1, meaning the pixel-rate clock enable; state advances only when it is high.
REQ-012 The block SHALL have port hsync, output, 1, meaning horizontal sync, active low.
REQ-013 The block SHALL have port vsync, output, 1, meaning vertical sync, active low.
REQ-014 The block SHALL have port column, output, 32 (int), meaning the current horizontal position 0..H_TOTAL-1.
REQ-015 The block SHALL have port row, output, 32 (int), meaning the current vertical position 0..V_TOTAL-1.
REQ-016 The block SHALL have port display_enable, output, 1, meaning the current position is in the visible area.
REQ-017 The block SHALL have port frame_start, output, 1, meaning a one-pixel pulse at position (0,0).
REQ-018 The block SHALL have port frame_count, output, 16, meaning the number of frames started since reset.

Function
REQ-019 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800 by default), and V_TOTAL SHALL equal V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525 by default).
REQ-020 The internal counters h_count/v_count SHALL advance only on cycles where pixel_enable=1 and reset=0; otherwise all state and outputs SHALL hold.
REQ-021 h_count SHALL increment by 1 each enabled cycle and wrap H_TOTAL-1 -> 0.
REQ-022 v_count SHALL increment by 1 only on the enabled cycle where h_count wraps, and SHALL wrap V_TOTAL-1 -> 0 on that same cycle.
REQ-023 All outputs SHALL be registered, updated on enabled cycles from the decode of the pre-advance counter value (latency: 1 enabled cycle from counter to outputs).
REQ-024 column SHALL equal the decoded h_count and row SHALL equal the decoded v_count, zero-extended; they are not clamped during blanking.
REQ-025 display_enable SHALL be 1 iff h<H_VISIBLE and v<V_VISIBLE.
REQ-026 hsync SHALL be 0 iff H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default).
REQ-027 vsync SHALL be 0 iff V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default), for the whole line.
REQ-028 frame_start SHALL be 1 only for the enabled cycle whose decoded position is (0,0), and SHALL be 0 otherwise, including cycles where pixel_enable=0.
REQ-029 frame_count SHALL increment by 1 on the same update in which frame_start is asserted, and SHALL wrap 65535 -> 0.
REQ-030 The first enabled cycle after reset SHALL present position (0,0) with frame_start=1 and frame_count=1.

Reset
REQ-031 While reset=1 at a clock edge, the block SHALL set h_count=0, v_count=0, hsync=1, vsync=1, column=0, row=0, display_enable=0, frame_start=0 and frame_count=0, regardless of pixel_enable.
REQ-032 Reset asserted mid-line or mid-frame SHALL take effect on the next edge, with no partial sync pulse continuing after reset.

Verification
REQ-033 Scenario: reset, then pixel_enable=1 continuously -> first update gives column=0, row=0, display_enable=1, frame_start=1, frame_count=1; column=639 is the last column with display_enable=1.
REQ-034 Scenario: count pixels per line -> hsync low for exactly 96 consecutive enabled cycles starting at column=656; the line period is 800.
REQ-035 Scenario: run one full frame -> vsync low for rows 490..491 (1600 enabled cycles); the next frame_start occurs exactly 420000 enabled cycles after the previous one; frame_count=2.
REQ-036 Scenario: pixel_enable toggled 1,0,1,0 -> outputs advance only on the high cycles; frame_start is never asserted for more than one cycle.
REQ-037 Scenario: reset asserted at row=300, column=400 -> next edge gives all outputs at reset values; after release, the first enabled update is (0,0) with frame_count=1.
REQ-038 Scenario: preload or run 65536 frames -> frame_count wraps 65535 -> 0 on frame_start.

Source files
------------

// File: rtl/vga_sync_generator.sv
// VGA timing generator: free-running pixel/line counters advanced by a
// pixel-rate clock enable, with registered sync, position, blanking and
// frame bookkeeping outputs decoded from the pre-advance counter value.
module vga_sync_generator #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic        vga_clock,
   input  logic        reset,
   input  logic        pixel_enable,
   output logic        hsync,
   output logic        vsync,
   output logic [31:0] column,
   output logic [31:0] row,
   output logic        display_enable,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Counter widths never drop below one bit, so degenerate one-pixel
   // timings still elaborate.
   localparam int H_W = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int V_W = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

   localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
   localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

   // Decode thresholds are kept 32 bits wide and unsigned so that a sync
   // end equal to the total line length cannot overflow the counter width.
   localparam logic [31:0] H_VIS_END    = 32'(H_VISIBLE);
   localparam logic [31:0] H_SYNC_START = 32'(H_VISIBLE + H_FRONT);
   localparam logic [31:0] H_SYNC_END   = 32'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [31:0] V_VIS_END    = 32'(V_VISIBLE);
   localparam logic [31:0] V_SYNC_START = 32'(V_VISIBLE + V_FRONT);
   localparam logic [31:0] V_SYNC_END   = 32'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [H_W-1:0] h_count_r;
   logic [V_W-1:0] v_count_r;
   logic [H_W-1:0] h_count_next_s;
   logic [V_W-1:0] v_count_next_s;
   logic           h_wrap_s;

   logic [31:0]    column_s;
   logic [31:0]    row_s;
   logic           display_enable_s;
   logic           hsync_s;
   logic           vsync_s;
   logic           frame_origin_s;
   logic [15:0]    frame_count_next_s;

   // Next counter values: pixel counter wraps at line end, line counter
   // steps only on that wrap and wraps at frame end on the same cycle.
   always_comb begin
      h_wrap_s       = 1'b0;
      h_count_next_s = h_count_r;
      v_count_next_s = v_count_r;
      if (h_count_r == H_LAST) begin
         h_wrap_s       = 1'b1;
         h_count_next_s = {H_W{1'b0}};
      end else begin
         h_count_next_s = h_count_r + H_W'(1);
      end
      if (h_wrap_s) begin
         if (v_count_r == V_LAST) begin
            v_count_next_s = {V_W{1'b0}};
         end else begin
            v_count_next_s = v_count_r + V_W'(1);
         end
      end else begin
         v_count_next_s = v_count_r;
      end
   end

   // Decode the current (pre-advance) position into output values.
   always_comb begin
      column_s           = 32'(h_count_r);
      row_s              = 32'(v_count_r);
      display_enable_s   = (column_s < H_VIS_END) && (row_s < V_VIS_END);
      hsync_s            = !((column_s >= H_SYNC_START) && (column_s < H_SYNC_END));
      vsync_s            = !((row_s >= V_SYNC_START) && (row_s < V_SYNC_END));
      frame_origin_s     = (h_count_r == {H_W{1'b0}}) && (v_count_r == {V_W{1'b0}});
      frame_count_next_s = frame_count;
      if (frame_origin_s) begin
         frame_count_next_s = frame_count + 16'd1;
      end else begin
         frame_count_next_s = frame_count;
      end
   end

   // Position counters: cleared by reset, advanced on enabled cycles only.
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         h_count_r <= {H_W{1'b0}};
         v_count_r <= {V_W{1'b0}};
      end else if (pixel_enable) begin
         h_count_r <= h_count_next_s;
         v_count_r <= v_count_next_s;
      end
   end

   // Output registers: load the decode on enabled cycles, hold otherwise,
   // except frame_start which is a single enabled-cycle pulse.
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         hsync          <= 1'b1;
         vsync          <= 1'b1;
         column         <= 32'd0;
         row            <= 32'd0;
         display_enable <= 1'b0;
         frame_start    <= 1'b0;
         frame_count    <= 16'd0;
      end else if (pixel_enable) begin
         hsync          <= hsync_s;
         vsync          <= vsync_s;
         column         <= column_s;
         row            <= row_s;
         display_enable <= display_enable_s;
         frame_start    <= frame_origin_s;
         frame_count    <= frame_count_next_s;
      end else begin
         frame_start    <= 1'b0;
      end
   end

endmodule
